// File: rtl/perf_counter_pkg.sv
// rtl/perf_counter_pkg.sv - shared constants, enums and address helper for the perf counter master
package perf_counter_pkg;

  localparam logic [3:0]  STOP_OFS          = 4'd0;
  localparam logic [3:0]  GO_OFS            = 4'd1;
  localparam logic [3:0]  EVT_OFS           = 4'd2;
  localparam logic [3:0]  TLO_OFS           = 4'd0;
  localparam logic [3:0]  THI_OFS           = 4'd1;
  localparam int unsigned SEC_STRIDE        = 4;
  localparam logic [31:0] GLOBAL_RESET_DATA = 32'h1;
  localparam logic [31:0] STOP_DATA         = 32'h0;
  localparam logic [31:0] GO_DATA           = 32'h0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD_CMD,
    ST_RD_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    GNT_RST,
    GNT_STOP,
    GNT_GO,
    GNT_SNAP
  } gnt_kind_t;

  function automatic logic [3:0] sec_addr(input logic [1:0] sec, input logic [3:0] ofs);
    return 4'(SEC_STRIDE) * {2'b00, sec} + ofs;
  endfunction

endpackage

// File: rtl/perf_req_arbiter.sv
// rtl/perf_req_arbiter.sv - pending request flags and fixed-priority grant for the perf counter master
// Incoming pulses are folded into the grant in the same cycle so an idle master can issue next cycle.
module perf_req_arbiter
  import perf_counter_pkg::*;
#(
  parameter int NSEC = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NSEC-1:0] start_req_i,
  input  logic [NSEC-1:0] stop_req_i,
  input  logic            reset_req_i,
  input  logic            snap_req_i,
  input  logic [1:0]      snap_sec_i,
  input  logic            take_i,
  output logic            gnt_valid_o,
  output gnt_kind_t       gnt_kind_o,
  output logic [1:0]      gnt_sec_o,
  output logic            pend_any_o,
  output logic            pend_snap_o
);

  logic [NSEC-1:0] pend_go_q, pend_go_d, eff_go;
  logic [NSEC-1:0] pend_stop_q, pend_stop_d, eff_stop;
  logic            pend_rst_q, pend_rst_d, eff_rst;
  logic            pend_snap_q, pend_snap_d, eff_snap;
  logic [1:0]      snap_sec_q, snap_sec_d, eff_sec;
  logic            stop_hit, go_hit;
  logic [1:0]      stop_sec, go_sec;

  // Apply this cycle's pulses: stop beats go for a section, global reset wipes go/stop.
  always_comb begin
    eff_rst  = pend_rst_q | reset_req_i;
    eff_stop = reset_req_i ? '0 : (pend_stop_q | stop_req_i);
    eff_go   = reset_req_i ? '0 : ((pend_go_q | start_req_i) & ~stop_req_i);
    eff_snap = pend_snap_q | snap_req_i;
    eff_sec  = snap_req_i ? snap_sec_i : snap_sec_q;
  end

  // Fixed priority: reset, lowest stop, lowest go, snapshot.
  always_comb begin
    stop_hit = 1'b0;
    stop_sec = '0;
    go_hit   = 1'b0;
    go_sec   = '0;
    for (int s = NSEC - 1; s >= 0; s--) begin
      if (eff_stop[s]) begin
        stop_hit = 1'b1;
        stop_sec = 2'(s);
      end
      if (eff_go[s]) begin
        go_hit = 1'b1;
        go_sec = 2'(s);
      end
    end
    gnt_valid_o = 1'b1;
    gnt_kind_o  = GNT_RST;
    gnt_sec_o   = '0;
    if (eff_rst) begin
      gnt_kind_o = GNT_RST;
    end else if (stop_hit) begin
      gnt_kind_o = GNT_STOP;
      gnt_sec_o  = stop_sec;
    end else if (go_hit) begin
      gnt_kind_o = GNT_GO;
      gnt_sec_o  = go_sec;
    end else if (eff_snap) begin
      gnt_kind_o = GNT_SNAP;
      gnt_sec_o  = eff_sec;
    end else begin
      gnt_valid_o = 1'b0;
    end
  end

  // Next pending state: a flag drops in the cycle its command is taken.
  always_comb begin
    pend_rst_d  = eff_rst;
    pend_stop_d = eff_stop;
    pend_go_d   = eff_go;
    pend_snap_d = eff_snap;
    snap_sec_d  = eff_sec;
    if (take_i && gnt_valid_o) begin
      unique case (gnt_kind_o)
        GNT_RST:  pend_rst_d = 1'b0;
        GNT_STOP: begin
          for (int s = 0; s < NSEC; s++) begin
            if (2'(s) == gnt_sec_o) pend_stop_d[s] = 1'b0;
          end
        end
        GNT_GO: begin
          for (int s = 0; s < NSEC; s++) begin
            if (2'(s) == gnt_sec_o) pend_go_d[s] = 1'b0;
          end
        end
        GNT_SNAP: pend_snap_d = 1'b0;
        default:  pend_rst_d = eff_rst;
      endcase
    end
  end

  // Pending flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_rst_q  <= 1'b0;
      pend_stop_q <= '0;
      pend_go_q   <= '0;
      pend_snap_q <= 1'b0;
      snap_sec_q  <= '0;
    end else begin
      pend_rst_q  <= pend_rst_d;
      pend_stop_q <= pend_stop_d;
      pend_go_q   <= pend_go_d;
      pend_snap_q <= pend_snap_d;
      snap_sec_q  <= snap_sec_d;
    end
  end

  assign pend_any_o  = pend_rst_q | (|pend_stop_q) | (|pend_go_q) | pend_snap_q;
  assign pend_snap_o = pend_snap_q;

endmodule

// File: rtl/perf_counter_master.sv
// rtl/perf_counter_master.sv - Avalon-MM master issuing perf counter go/stop/reset writes and snapshots
// Optional waitrequest watchdog and sticky err: define PERF_MASTER_TIMEOUT_EN.
module perf_counter_master
  import perf_counter_pkg::*;
#(
  parameter int NSEC    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NSEC-1:0] start_req,
  input  logic [NSEC-1:0] stop_req,
  input  logic            reset_req,
  input  logic            snap_req,
  input  logic [1:0]      snap_sec,
  output logic            snap_ready,
  output logic            snap_valid,
  output logic [63:0]     snap_time,
  output logic [31:0]     snap_event,
  output logic            busy,
  output logic [3:0]      m_address,
  output logic            m_write,
  output logic [31:0]     m_writedata,
  output logic            m_read,
  input  logic [31:0]     m_readdata,
  input  logic            m_readdatavalid,
  input  logic            m_waitrequest,
  output logic            err
);

  state_t      state_q, state_d;
  logic        m_write_q, m_write_d, m_read_q, m_read_d;
  logic [3:0]  m_address_q, m_address_d;
  logic [31:0] m_writedata_q, m_writedata_d;
  logic [1:0]  word_idx_q, word_idx_d, rd_sec_q, rd_sec_d;
  logic [31:0] lo_q, lo_d, hi_q, hi_d, snap_event_q, snap_event_d;
  logic [63:0] snap_time_q, snap_time_d;
  logic        stall;
  logic        snap_acc, gnt_valid, pend_any, pend_snap;
  gnt_kind_t   gnt_kind;
  logic [1:0]  gnt_sec;

`ifdef PERF_MASTER_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        err_q, err_d;
`endif

  assign snap_ready = !pend_snap && (state_q != ST_RD_CMD) && (state_q != ST_RD_WAIT);
  assign snap_acc   = snap_req && snap_ready && ({30'd0, snap_sec} < 32'(NSEC));

  perf_req_arbiter #(.NSEC(NSEC)) u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_req_i (start_req),
    .stop_req_i  (stop_req),
    .reset_req_i (reset_req),
    .snap_req_i  (snap_acc),
    .snap_sec_i  (snap_sec),
    .take_i      (state_q == ST_IDLE),
    .gnt_valid_o (gnt_valid),
    .gnt_kind_o  (gnt_kind),
    .gnt_sec_o   (gnt_sec),
    .pend_any_o  (pend_any),
    .pend_snap_o (pend_snap)
  );

  // Next-state and registered bus outputs; snapshot words collect in lo/hi until the event word lands.
  always_comb begin
    state_d       = state_q;
    m_write_d     = m_write_q;
    m_read_d      = m_read_q;
    m_address_d   = m_address_q;
    m_writedata_d = m_writedata_q;
    word_idx_d    = word_idx_q;
    rd_sec_d      = rd_sec_q;
    lo_d          = lo_q;
    hi_d          = hi_q;
    snap_time_d   = snap_time_q;
    snap_event_d  = snap_event_q;
    stall         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          unique case (gnt_kind)
            GNT_RST: begin
              state_d       = ST_WR;
              m_write_d     = 1'b1;
              m_address_d   = sec_addr(2'd0, STOP_OFS);
              m_writedata_d = GLOBAL_RESET_DATA;
            end
            GNT_STOP: begin
              state_d       = ST_WR;
              m_write_d     = 1'b1;
              m_address_d   = sec_addr(gnt_sec, STOP_OFS);
              m_writedata_d = STOP_DATA;
            end
            GNT_GO: begin
              state_d       = ST_WR;
              m_write_d     = 1'b1;
              m_address_d   = sec_addr(gnt_sec, GO_OFS);
              m_writedata_d = GO_DATA;
            end
            default: begin
              state_d     = ST_RD_CMD;
              m_read_d    = 1'b1;
              m_address_d = sec_addr(gnt_sec, TLO_OFS);
              rd_sec_d    = gnt_sec;
              word_idx_d  = 2'd0;
            end
          endcase
        end
      end
      ST_WR: begin
        stall = m_waitrequest;
        if (!m_waitrequest) begin
          m_write_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      ST_RD_CMD: begin
        stall = m_waitrequest;
        if (!m_waitrequest) begin
          m_read_d = 1'b0;
          state_d  = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        stall = 1'b1;
        if (m_readdatavalid) begin
          stall = 1'b0;
          unique case (word_idx_q)
            2'd0: begin
              lo_d        = m_readdata;
              m_address_d = sec_addr(rd_sec_q, THI_OFS);
            end
            2'd1: begin
              hi_d        = m_readdata;
              m_address_d = sec_addr(rd_sec_q, EVT_OFS);
            end
            default: begin
              snap_time_d  = {hi_q, lo_q};
              snap_event_d = m_readdata;
            end
          endcase
          if (word_idx_q == 2'd2) begin
            state_d = ST_DONE;
          end else begin
            word_idx_d = word_idx_q + 2'd1;
            m_read_d   = 1'b1;
            state_d    = ST_RD_CMD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef PERF_MASTER_TIMEOUT_EN
    wd_d  = '0;
    err_d = err_q;
    if (stall) begin
      if (wd_q == 16'(TIMEOUT - 1)) begin
        m_write_d = 1'b0;
        m_read_d  = 1'b0;
        state_d   = ST_IDLE;
        err_d     = 1'b1;
      end else begin
        wd_d = wd_q + 16'd1;
      end
    end
`endif
  end

  // State, bus and snapshot registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      m_write_q     <= 1'b0;
      m_read_q      <= 1'b0;
      m_address_q   <= '0;
      m_writedata_q <= '0;
      word_idx_q    <= '0;
      rd_sec_q      <= '0;
      lo_q          <= '0;
      hi_q          <= '0;
      snap_time_q   <= '0;
      snap_event_q  <= '0;
    end else begin
      state_q       <= state_d;
      m_write_q     <= m_write_d;
      m_read_q      <= m_read_d;
      m_address_q   <= m_address_d;
      m_writedata_q <= m_writedata_d;
      word_idx_q    <= word_idx_d;
      rd_sec_q      <= rd_sec_d;
      lo_q          <= lo_d;
      hi_q          <= hi_d;
      snap_time_q   <= snap_time_d;
      snap_event_q  <= snap_event_d;
    end
  end

`ifdef PERF_MASTER_TIMEOUT_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  logic unused_watchdog;
  assign unused_watchdog = stall ^ (TIMEOUT == 0);
  assign err = 1'b0;
`endif

  assign m_write     = m_write_q;
  assign m_read      = m_read_q;
  assign m_address   = m_address_q;
  assign m_writedata = m_writedata_q;
  assign snap_valid  = (state_q == ST_DONE);
  assign snap_time   = snap_time_q;
  assign snap_event  = snap_event_q;
  assign busy        = (state_q != ST_IDLE) || pend_any;

endmodule
